// File: rtl/mem_to_dram_pkg.sv
// Shared types and width helpers for the memory_to_dram word-to-byte serializer.
package mem_to_dram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_IN_BITWIDTH  = 163;
    localparam int DEF_DATA_OUT_BITWIDTH = 8;
    localparam int DEF_ADDR_BITWIDTH     = 10;

    // Bit buffer must hold a partial byte (up to dout-1 bits) plus one whole word.
    function automatic int buf_width(input int din, input int dout);
        return din + dout - 1;
    endfunction

    function automatic int fill_width(input int din, input int dout);
        return $clog2(din + dout);
    endfunction

    function automatic int count_width(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int byte_count_width(input int addr_w, input int din);
        return addr_w + $clog2(din) + 1;
    endfunction

endpackage

// File: rtl/memory_to_dram_bit_unpack_buffer.sv
// MSB-aligned bit buffer: merges prefetched words behind the residual bits and
// emits bytes through a registered valid/ready output stage.
module bit_unpack_buffer
    import mem_to_dram_pkg::*;
#(
    parameter int DATA_IN_BITWIDTH  = DEF_DATA_IN_BITWIDTH,
    parameter int DATA_OUT_BITWIDTH = DEF_DATA_OUT_BITWIDTH
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         pf_valid_i,
    input  logic [DATA_IN_BITWIDTH-1:0]  pf_data_i,
    input  logic                         all_merged_i,
    input  logic                         ready_i,
    output logic                         merge_o,
    output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
    output logic                         data_valid_o,
    output logic                         data_last_o
);

    localparam int BUF_W  = buf_width(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
    localparam int FILL_W = fill_width(DATA_IN_BITWIDTH, DATA_OUT_BITWIDTH);
    localparam logic [FILL_W-1:0] OUT_F = FILL_W'(DATA_OUT_BITWIDTH);
    localparam logic [FILL_W-1:0] IN_F  = FILL_W'(DATA_IN_BITWIDTH);

    logic [BUF_W-1:0]  bits_q;
    logic [FILL_W-1:0] fill_q;
    logic [BUF_W-1:0]  word_ext;
    logic [BUF_W-1:0]  word_aligned;
    logic              full;
    logic              tail;
    logic              load;

    always_comb begin
        full         = (fill_q >= OUT_F);
        tail         = all_merged_i && (fill_q != '0) && !full;
        load         = (full || tail) && (!data_valid_o || ready_i);
        // A tail can only occur once every word is merged, so merge and load never overlap.
        merge_o      = pf_valid_i && !full;
        word_ext     = BUF_W'(pf_data_i);
        word_aligned = (word_ext << (BUF_W - DATA_IN_BITWIDTH)) >> fill_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bits_q       <= '0;
            fill_q       <= '0;
            data_out_o   <= '0;
            data_valid_o <= 1'b0;
            data_last_o  <= 1'b0;
        end else begin
            if (load) begin
                data_out_o   <= bits_q[BUF_W-1 -: DATA_OUT_BITWIDTH];
                data_valid_o <= 1'b1;
                data_last_o  <= all_merged_i && (tail || (fill_q == OUT_F));
                if (tail) begin
                    bits_q <= '0;
                    fill_q <= '0;
                end else begin
                    bits_q <= bits_q << DATA_OUT_BITWIDTH;
                    fill_q <= fill_q - OUT_F;
                end
            end else if (ready_i) begin
                data_valid_o <= 1'b0;
                data_last_o  <= 1'b0;
            end
            if (merge_o) begin
                bits_q <= bits_q | word_aligned;
                fill_q <= fill_q + IN_F;
            end
        end
    end

endmodule

// File: rtl/memory_to_dram.sv
// Fetches N wide words from BRAM and serializes them as a contiguous MSB-first
// byte stream. Optional bytes_sent_o counter enabled by MEM_TO_DRAM_BYTE_COUNT_EN.
module memory_to_dram
    import mem_to_dram_pkg::*;
#(
    parameter int DATA_IN_BITWIDTH  = DEF_DATA_IN_BITWIDTH,
    parameter int DATA_OUT_BITWIDTH = DEF_DATA_OUT_BITWIDTH,
    parameter int ADDR_BITWIDTH     = DEF_ADDR_BITWIDTH
) (
    input  logic                         clk_i,
    input  logic                         mem_to_dram_rst_n_i,
    input  logic                         start_i,
    input  logic [ADDR_BITWIDTH-1:0]     base_addr_i,
    input  logic [ADDR_BITWIDTH:0]       num_words_i,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         memory_read_enable_o,
    output logic [ADDR_BITWIDTH-1:0]     memory_addr_o,
    input  logic [DATA_IN_BITWIDTH-1:0]  memory_data_i,
    output logic [DATA_OUT_BITWIDTH-1:0] data_out_o,
    output logic                         data_valid_o,
    input  logic                         data_ready_i,
    output logic                         data_last_o
`ifdef MEM_TO_DRAM_BYTE_COUNT_EN
    ,
    output logic [byte_count_width(ADDR_BITWIDTH, DATA_IN_BITWIDTH)-1:0] bytes_sent_o
`endif
);

    localparam int CNT_W = count_width(ADDR_BITWIDTH);

    state_t                      state;
    logic [ADDR_BITWIDTH-1:0]    base_q;
    logic [CNT_W-1:0]            num_words_q;
    logic [CNT_W-1:0]            issued_q;
    logic [CNT_W-1:0]            merged_q;
    logic                        capture_q;
    logic                        pf_valid_q;
    logic [DATA_IN_BITWIDTH-1:0] pf_data_q;
    logic                        merge;
    logic                        all_merged;
    logic                        issue;
    logic                        accept;

    always_comb begin
        all_merged = (merged_q == num_words_q);
        accept     = data_valid_o && data_ready_i;
        // One read outstanding at most: strobe cycle plus data-return cycle.
        issue      = (state == ST_RUN) && !pf_valid_q && !memory_read_enable_o
                     && !capture_q && (issued_q < num_words_q);
    end

    always_ff @(posedge clk_i or negedge mem_to_dram_rst_n_i) begin
        if (!mem_to_dram_rst_n_i) begin
            state                <= ST_IDLE;
            base_q               <= '0;
            num_words_q          <= '0;
            issued_q             <= '0;
            merged_q             <= '0;
            capture_q            <= 1'b0;
            pf_valid_q           <= 1'b0;
            pf_data_q            <= '0;
            busy_o               <= 1'b0;
            done_o               <= 1'b0;
            memory_read_enable_o <= 1'b0;
            memory_addr_o        <= '0;
        end else begin
            memory_read_enable_o <= issue;
            capture_q            <= memory_read_enable_o;
            done_o               <= 1'b0;

            if (issue) begin
                memory_addr_o <= base_q + issued_q[ADDR_BITWIDTH-1:0];
                issued_q      <= issued_q + CNT_W'(1);
            end

            if (capture_q) begin
                pf_data_q  <= memory_data_i;
                pf_valid_q <= 1'b1;
            end else if (merge) begin
                pf_valid_q <= 1'b0;
            end

            if (merge) begin
                merged_q <= merged_q + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        base_q      <= base_addr_i;
                        num_words_q <= num_words_i;
                        issued_q    <= '0;
                        merged_q    <= '0;
                        if (num_words_i == '0) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= ST_RUN;
                            busy_o <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    // The last flag is only raised once the buffer drains with every word merged.
                    if (accept && data_last_o) begin
                        state  <= ST_DONE;
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    bit_unpack_buffer #(
        .DATA_IN_BITWIDTH  (DATA_IN_BITWIDTH),
        .DATA_OUT_BITWIDTH (DATA_OUT_BITWIDTH)
    ) u_unpack (
        .clk_i        (clk_i),
        .rst_n_i      (mem_to_dram_rst_n_i),
        .pf_valid_i   (pf_valid_q),
        .pf_data_i    (pf_data_q),
        .all_merged_i (all_merged),
        .ready_i      (data_ready_i),
        .merge_o      (merge),
        .data_out_o   (data_out_o),
        .data_valid_o (data_valid_o),
        .data_last_o  (data_last_o)
    );

`ifdef MEM_TO_DRAM_BYTE_COUNT_EN
    always_ff @(posedge clk_i or negedge mem_to_dram_rst_n_i) begin
        if (!mem_to_dram_rst_n_i) begin
            bytes_sent_o <= '0;
        end else if ((state == ST_IDLE) && start_i) begin
            bytes_sent_o <= '0;
        end else if (accept) begin
            bytes_sent_o <= bytes_sent_o + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_memory_to_dram.sv
// Scoreboard bench for memory_to_dram: directed runs, expected bytes queued at
// start, a negedge monitor pops and compares each accepted byte.
module tb_memory_to_dram;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [9:0]   base_addr_i;
    logic [10:0]  num_words_i;
    logic         busy_o;
    logic         done_o;
    logic         memory_read_enable_o;
    logic [9:0]   memory_addr_o;
    logic [162:0] memory_data_i;
    logic [7:0]   data_out_o;
    logic         data_valid_o;
    logic         data_ready_i = 1'b1;
    logic         data_last_o;
`ifdef MEM_TO_DRAM_BYTE_COUNT_EN
    logic [18:0]  bytes_sent;
`endif

    always #5 clk = ~clk;

    memory_to_dram dut (
        .clk_i                (clk),
        .mem_to_dram_rst_n_i  (rst_n),
        .start_i              (start_i),
        .base_addr_i          (base_addr_i),
        .num_words_i          (num_words_i),
        .busy_o               (busy_o),
        .done_o               (done_o),
        .memory_read_enable_o (memory_read_enable_o),
        .memory_addr_o        (memory_addr_o),
        .memory_data_i        (memory_data_i),
        .data_out_o           (data_out_o),
        .data_valid_o         (data_valid_o),
        .data_ready_i         (data_ready_i),
        .data_last_o          (data_last_o)
`ifdef MEM_TO_DRAM_BYTE_COUNT_EN
        ,
        .bytes_sent_o         (bytes_sent)
`endif
    );

    logic [162:0] mem [0:1023];

    always @(posedge clk) begin
        if (memory_read_enable_o) memory_data_i <= mem[memory_addr_o];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    logic [8:0]  exp_q [$];
    logic [9:0]  rd_q [$];
    int          bytes_rx = 0;
    int          last_acc_cyc = -1;
    int          start_cyc = 0;
    bit          rand_ready = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;
    logic [8:0]  e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [162:0] mk_word(input int a);
        logic [31:0]  s;
        logic [191:0] t;
        s = 32'h9E3779B9 * 32'(a + 1);
        t = {s, ~s, s ^ 32'h5555AAAA, {s[15:0], s[31:16]}, s + 32'h01234567, ~s ^ 32'h0F0F0F0F};
        return t[191:29];
    endfunction

    // Golden model: concatenate words MSB-first into a bit queue, cut into bytes.
    task automatic push_model(input logic [9:0] b, input int n);
        bit           bq [$];
        logic [162:0] w;
        logic [7:0]   by;
        for (int k = 0; k < n; k++) begin
            w = mem[10'(b + 10'(k))];
            for (int j = 162; j >= 0; j--) bq.push_back(w[j]);
        end
        while (bq.size() > 0) begin
            by = '0;
            for (int j = 7; j >= 0; j--) if (bq.size() > 0) by[j] = bq.pop_front();
            exp_q.push_back({bq.size() == 0, by});
        end
    endtask

    // Ready driver: always high unless random backpressure is enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            data_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: reads, stall stability and byte scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (memory_read_enable_o) rd_q.push_back(memory_addr_o);
            if (prev_stall) begin
                chk("stall_valid", 64'(data_valid_o), 64'(1'b1));
                chk("stall_data", 64'(data_out_o), 64'(prev_data));
                chk("stall_last", 64'(data_last_o), 64'(prev_last));
            end
            if (data_valid_o && data_ready_i) begin
                bytes_rx++;
                if (data_last_o) last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    fail("unexpected_byte");
                end else begin
                    e = exp_q.pop_front();
                    chk("byte", 64'({data_last_o, data_out_o}), 64'(e));
                end
            end
            prev_stall = data_valid_o && !data_ready_i;
            prev_data  = data_out_o;
            prev_last  = data_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_run(input logic [9:0] b, input logic [10:0] n);
        rd_q.delete();
        bytes_rx     = 0;
        last_acc_cyc = -1;
        @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = b;
        num_words_i = n;
        start_cyc   = cyc;
        @(negedge clk);
        start_i = 1'b0;
        if (n != 0) chk("busy_after_start", 64'(busy_o), 64'(1'b1));
    endtask

    task automatic finish_run(input logic [9:0] b, input int n, input int exp_bytes);
        int k;
        k = 0;
        while (!done_o && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (!done_o) begin
            fail("done_timeout");
        end else begin
            chk("done_cycle", 64'(cyc), 64'((n == 0) ? start_cyc + 1 : last_acc_cyc + 1));
        end
        chk("byte_count", 64'(bytes_rx), 64'(exp_bytes));
        chk("queue_empty", 64'(exp_q.size()), 64'(0));
        chk("read_count", 64'(rd_q.size()), 64'(n));
        for (int i = 0; i < rd_q.size() && i < n; i++)
            chk("read_addr", 64'(rd_q[i]), 64'(10'(b + 10'(i))));
        @(negedge clk);
        chk("done_pulse_end", 64'(done_o), 64'(1'b0));
        chk("busy_end", 64'(busy_o), 64'(1'b0));
    endtask

    initial begin
        logic [167:0] pat;
        int           k;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        num_words_i = '0;
        for (int a = 0; a < 1024; a++) mem[a] = mk_word(a);
        pat    = {21{8'h5A}};
        mem[5] = pat[167:5];

        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_done", 64'(done_o), 64'(0));
        chk("rst_ren", 64'(memory_read_enable_o), 64'(0));
        chk("rst_addr", 64'(memory_addr_o), 64'(0));
        chk("rst_valid", 64'(data_valid_o), 64'(0));
        chk("rst_last", 64'(data_last_o), 64'(0));
        chk("rst_data", 64'(data_out_o), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // N=1: twenty 0x5A bytes then the 3 leftover bits 010 padded -> 0x40, last.
        for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, 8'h5A});
        exp_q.push_back({1'b1, 8'h40});
        start_run(10'd5, 11'd1);
        finish_run(10'd5, 1, 21);

        // N=8 wrapping the address space; 1304 bits = exactly 163 bytes.
        push_model(10'h3FE, 8);
        start_run(10'h3FE, 11'd8);
        finish_run(10'h3FE, 8, 163);

        // N=3 under random backpressure.
        rand_ready = 1'b1;
        push_model(10'd300, 3);
        start_run(10'd300, 11'd3);
        finish_run(10'd300, 3, 62);
        rand_ready = 1'b0;
        @(negedge clk);

        // Zero-length start.
        start_run(10'd50, 11'd0);
        finish_run(10'd50, 0, 0);

        // Start pulse while busy is ignored.
        push_model(10'd20, 2);
        start_run(10'd20, 11'd2);
        repeat (5) @(negedge clk);
        start_i     = 1'b1;
        base_addr_i = 10'd600;
        num_words_i = 11'd5;
        @(negedge clk);
        start_i = 1'b0;
        finish_run(10'd20, 2, 41);
`ifdef MEM_TO_DRAM_BYTE_COUNT_EN
        chk("bytes_sent_done", 64'(bytes_sent), 64'(41));
        repeat (3) @(negedge clk);
        chk("bytes_sent_hold", 64'(bytes_sent), 64'(41));
`endif

        // Asynchronous reset mid-transfer.
        push_model(10'd40, 2);
        start_run(10'd40, 11'd2);
        k = 0;
        while (bytes_rx < 10 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (bytes_rx < 10) fail("abort_wait_timeout");
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_valid", 64'(data_valid_o), 64'(0));
        chk("abort_last", 64'(data_last_o), 64'(0));
        chk("abort_data", 64'(data_out_o), 64'(0));
        chk("abort_busy", 64'(busy_o), 64'(0));
        chk("abort_ren", 64'(memory_read_enable_o), 64'(0));
        chk("abort_done", 64'(done_o), 64'(0));
        exp_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 64'(done_o), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);
        push_model(10'd100, 1);
        start_run(10'd100, 11'd1);
        finish_run(10'd100, 1, 21);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
